ts_usb_pkt_aligner: RTL and testbench
=====================================

TS_USB_PKT_ALIGNER -- requirements
Module: ts_usb_pkt_aligner

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2048, byte capacity of the internal FIFO (power of two).
REQ-002 SHALL have parameter AFULL_LVL, default 1792, FIFO level at or above which ts_usb_almost_full asserts.
REQ-003 SHALL have parameter PKT_LEN, default 188, TS packet length in bytes.
REQ-004 SHALL have parameter LOCK_CNT, default 3, number of consecutive PKT_LEN-spaced 0x47 bytes required to lock.
REQ-005 SHALL have port clk, input, 1, 60 MHz system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port ts_usb_data, input, 8, byte from the USB TS stage.
REQ-008 SHALL have port ts_usb_writereq, input, 1, single-cycle write strobe for ts_usb_data.
REQ-009 SHALL have port ts_usb_almost_full, output, 1, back-pressure to the USB TS stage.
REQ-010 SHALL have port ts_out_data, output, 8, aligned TS byte to the CI/TS mux.
REQ-011 SHALL have port ts_out_valid, output, 1, ts_out_data is valid.
REQ-012 SHALL have port ts_out_start, output, 1, qualifies the first (0x47) byte of a packet.
REQ-013 SHALL have port ts_out_ready, input, 1, consumer accepts the byte when valid and ready are high together.
REQ-014 SHALL have port locked, output, 1, packet alignment achieved.
REQ-015 SHALL have ports sync_loss_cnt and overflow_cnt, output, 16 each, saturating event counters.
REQ-016 SHALL have port fifo_level, output, 12, current FIFO occupancy.

Function
REQ-017 A write with ts_usb_writereq=1 SHALL enqueue ts_usb_data unless the FIFO is full; a write while full SHALL be dropped and SHALL increment overflow_cnt, even if a read occurs in the same cycle.
REQ-018 ts_usb_almost_full SHALL be registered and equal (fifo_level >= AFULL_LVL), one cycle after the level change.
REQ-019 FIFO read latency SHALL be one cycle; simultaneous read and write when not full SHALL leave fifo_level unchanged.
REQ-020 States SHALL be HUNT, VERIFY, LOCKED.
REQ-021 HUNT: pop and discard bytes; on 0x47 go to VERIFY with byte index 1 and hit count 1.
REQ-022 VERIFY: pop and discard bytes; at index PKT_LEN, 0x47 increments hit count and resets the index to 1, and anything else returns to HUNT; reaching LOCK_CNT hits enters LOCKED, and that 0x47 is the first byte output.
REQ-023 LOCKED: forward bytes in order; at index 0 a non-0x47 byte SHALL be discarded, increment sync_loss_cnt and go to HUNT; locked SHALL be 1 only in LOCKED.
REQ-024 ts_out_start SHALL be 1 exactly on the index-0 byte of each forwarded packet.
REQ-025 While ts_out_valid=1 and ts_out_ready=0, ts_out_data and ts_out_start SHALL hold and no FIFO pop SHALL occur.
REQ-026 With the FIFO non-empty and ts_out_ready=1 in LOCKED, throughput SHALL be one byte per cycle.
REQ-027 FIFO empty SHALL stall any state with no index advance; ts_out_valid SHALL drop when no byte is present.
REQ-028 Counters SHALL saturate at 0xFFFF; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 Reset SHALL empty the FIFO, set the state to HUNT, and clear all outputs to 0 (including counters and almost_full), taking effect on the next edge regardless of state or a pending handshake.

Structure
REQ-030 State encodings and the constants 0x47 and the 16-bit counter maximum SHALL live in the shared joker_ts_pkg package.
REQ-031 The FIFO SHALL be a separate sub-module, ts_byte_fifo (synchronous, registered read, level output).

Verification
REQ-032 Write 4 aligned packets (0x47, 1..187) with ready=1: the 3rd packet start is output first with start=1, then 376 bytes, and locked=1.
REQ-033 Write 5 junk bytes then 4 aligned packets: the junk is discarded and the output begins at the 3rd packet start.
REQ-034 Locked, the 5th packet start is corrupted to 0x00: sync_loss_cnt=1, locked=0, and output resumes only after 3 new aligned hits.
REQ-035 Hold ts_out_ready=0 while writing 1800 bytes: almost_full=1 at level 1792; 2049 writes give overflow_cnt=1 and fifo_level=2048.
REQ-036 Ready toggles 1/0 every cycle during LOCKED: no byte is lost or duplicated, and data holds while stalled.
REQ-037 Assert reset mid-packet in LOCKED: the next cycle shows fifo_level=0, valid=0, locked=0, state HUNT.

Source files
------------

// File: rtl/joker_ts_pkg.sv
// Shared TS-path definitions: aligner state encoding, sync byte and counter ceiling.
package joker_ts_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_st_t;

  localparam logic [7:0]  TS_SYNC = 8'h47;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ts_byte_fifo.sv
// Byte FIFO with registered read data (one-cycle latency) and an occupancy level.
module ts_byte_fifo #(
  parameter int DEPTH = 2048,
  parameter int LVL_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [7:0]       i_wdata,
  input  logic             i_rd,
  output logic [7:0]       o_rdata,
  output logic [LVL_W-1:0] o_level,
  output logic             o_empty,
  output logic             o_wr_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [LVL_W-1:0] r_level;
  logic [7:0]       r_rdata;
  logic             w_full, w_wr_ok, w_rd_ok;

  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_wr_ok   = i_wr && !w_full;
  assign w_rd_ok   = i_rd && !o_empty;
  // Full is judged on the current level, so a same-cycle read never rescues a write.
  assign o_wr_drop = i_wr && w_full;
  assign o_rdata   = r_rdata;
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
      if (w_rd_ok) begin
        r_rptr  <= r_rptr + AW'(1);
        r_rdata <= r_mem[r_rptr];
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ts_usb_pkt_aligner.sv
// Buffers USB TS bytes, finds 188-byte packet alignment on 0x47, and forwards aligned packets.
module ts_usb_pkt_aligner
  import joker_ts_pkg::*;
#(
  parameter int FIFO_DEPTH = 2048,
  parameter int AFULL_LVL  = 1792,
  parameter int PKT_LEN    = 188,
  parameter int LOCK_CNT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ts_usb_data,
  input  logic        ts_usb_writereq,
  output logic        ts_usb_almost_full,
  output logic [7:0]  ts_out_data,
  output logic        ts_out_valid,
  output logic        ts_out_start,
  input  logic        ts_out_ready,
  output logic        locked,
  output logic [15:0] sync_loss_cnt,
  output logic [15:0] overflow_cnt,
  output logic [11:0] fifo_level
);

  localparam int LVL_W = 12;
  localparam int IDX_W = $clog2(PKT_LEN + 1);
  localparam int HIT_W = $clog2(LOCK_CNT + 1);

  align_st_t        r_state, w_nxt_state;
  logic [IDX_W-1:0] r_idx, w_nxt_idx;
  logic [HIT_W-1:0] r_hits, w_nxt_hits;
  logic             r_rd_vld;
  logic             r_out_valid, r_out_start, r_afull;
  logic [7:0]       r_out_data;
  logic [15:0]      r_sync_loss, r_ovf;

  logic [7:0]       w_rdata;
  logic [LVL_W-1:0] w_level;
  logic             w_empty, w_wr_drop;
  logic             w_pop, w_consume, w_load, w_load_start, w_loss;
  logic             w_out_free, w_stall, w_is_sync;

  ts_byte_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_wr     (ts_usb_writereq),
    .i_wdata  (ts_usb_data),
    .i_rd     (w_pop),
    .o_rdata  (w_rdata),
    .o_level  (w_level),
    .o_empty  (w_empty),
    .o_wr_drop(w_wr_drop)
  );

  assign w_out_free = !r_out_valid || ts_out_ready;
  assign w_stall    = r_out_valid && !ts_out_ready;
  assign w_is_sync  = (w_rdata == TS_SYNC);

  // r_rd_vld marks a popped byte sitting in the FIFO read register awaiting a decision.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_idx    = r_idx;
    w_nxt_hits   = r_hits;
    w_consume    = 1'b0;
    w_load       = 1'b0;
    w_load_start = 1'b0;
    w_loss       = 1'b0;
    if (r_rd_vld) begin
      case (r_state)
        ST_HUNT: begin
          w_consume = 1'b1;
          if (w_is_sync) begin
            w_nxt_state = ST_VERIFY;
            w_nxt_idx   = IDX_W'(1);
            w_nxt_hits  = HIT_W'(1);
          end
        end
        ST_VERIFY: begin
          w_consume = 1'b1;
          if (r_idx != IDX_W'(PKT_LEN)) begin
            w_nxt_idx = r_idx + IDX_W'(1);
          end else if (!w_is_sync) begin
            w_nxt_state = ST_HUNT;
          end else if (r_hits != HIT_W'(LOCK_CNT - 1)) begin
            w_nxt_hits = r_hits + HIT_W'(1);
            w_nxt_idx  = IDX_W'(1);
          end else if (w_out_free) begin
            // The locking sync byte is itself the first forwarded byte.
            w_nxt_state  = ST_LOCKED;
            w_nxt_idx    = IDX_W'(1);
            w_load       = 1'b1;
            w_load_start = 1'b1;
          end else begin
            w_consume = 1'b0;
          end
        end
        ST_LOCKED: begin
          if (w_out_free) begin
            w_consume = 1'b1;
            if (r_idx == '0) begin
              if (w_is_sync) begin
                w_load       = 1'b1;
                w_load_start = 1'b1;
                w_nxt_idx    = IDX_W'(1);
              end else begin
                w_loss      = 1'b1;
                w_nxt_state = ST_HUNT;
              end
            end else begin
              w_load    = 1'b1;
              w_nxt_idx = (r_idx == IDX_W'(PKT_LEN - 1)) ? '0 : r_idx + IDX_W'(1);
            end
          end
        end
        default: w_nxt_state = ST_HUNT;
      endcase
    end
    w_pop = !w_empty && !w_stall && (!r_rd_vld || w_consume);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_HUNT;
      r_idx       <= '0;
      r_hits      <= '0;
      r_rd_vld    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_start <= 1'b0;
      r_afull     <= 1'b0;
      r_sync_loss <= '0;
      r_ovf       <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_hits  <= w_nxt_hits;
      if (w_pop)          r_rd_vld <= 1'b1;
      else if (w_consume) r_rd_vld <= 1'b0;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rdata;
        r_out_start <= w_load_start;
      end else if (ts_out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_afull <= (w_level >= LVL_W'(AFULL_LVL));
      if (w_loss)    r_sync_loss <= sat_inc(r_sync_loss);
      if (w_wr_drop) r_ovf       <= sat_inc(r_ovf);
    end
  end

  assign ts_usb_almost_full = r_afull;
  assign ts_out_data        = r_out_data;
  assign ts_out_valid       = r_out_valid;
  assign ts_out_start       = r_out_start;
  assign locked             = (r_state == ST_LOCKED);
  assign sync_loss_cnt      = r_sync_loss;
  assign overflow_cnt       = r_ovf;
  assign fifo_level         = w_level;

endmodule

// File: tb/tb_ts_usb_pkt_aligner.sv
// Directed bench for ts_usb_pkt_aligner: packet scenario table plus overflow and reset sequences.
module tb_ts_usb_pkt_aligner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ts_usb_data = 8'h00;
  logic        ts_usb_writereq = 1'b0;
  logic        ts_usb_almost_full;
  logic [7:0]  ts_out_data;
  logic        ts_out_valid;
  logic        ts_out_start;
  logic        ts_out_ready;
  logic        locked;
  logic [15:0] sync_loss_cnt;
  logic [15:0] overflow_cnt;
  logic [11:0] fifo_level;

  ts_usb_pkt_aligner dut (
    .clk               (clk),
    .reset             (reset),
    .ts_usb_data       (ts_usb_data),
    .ts_usb_writereq   (ts_usb_writereq),
    .ts_usb_almost_full(ts_usb_almost_full),
    .ts_out_data       (ts_out_data),
    .ts_out_valid      (ts_out_valid),
    .ts_out_start      (ts_out_start),
    .ts_out_ready      (ts_out_ready),
    .locked            (locked),
    .sync_loss_cnt     (sync_loss_cnt),
    .overflow_cnt      (overflow_cnt),
    .fifo_level        (fifo_level)
  );

  always #8 clk = ~clk;

  typedef struct {
    string      nm;
    int         junk;
    int         npkt;
    int         bad_pkt;
    logic [7:0] xm;
    int         rm;
    int         lo0, hi0, lo1, hi1;
    int         exp_lock;
    int         exp_sl;
  } vec_t;

  vec_t       tbl [4];
  int         errors = 0;
  int         checks = 0;
  int         hold_err = 0;
  int         rmode = 0;
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];
  logic       pv = 1'b0;
  logic [8:0] pd = '0;

  // 0: ready high, 1: ready toggles every cycle, 2: ready low
  initial begin
    ts_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       ts_out_ready = 1'b1;
        1:       ts_out_ready = ~ts_out_ready;
        default: ts_out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      pv <= 1'b0;
    end else begin
      if (pv && !(ts_out_valid && {ts_out_start, ts_out_data} == pd)) hold_err <= hold_err + 1;
      pv <= ts_out_valid && !ts_out_ready;
      pd <= {ts_out_start, ts_out_data};
      if (ts_out_valid && ts_out_ready) got_q.push_back({ts_out_start, ts_out_data});
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pb(input int i, input logic [7:0] xm);
    return (i == 0) ? 8'h47 : (8'(i) ^ xm);
  endfunction

  task automatic put(input logic [7:0] b);
    ts_usb_data     = b;
    ts_usb_writereq = 1'b1;
    @(posedge clk); #1;
    ts_usb_writereq = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ts_usb_writereq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic add_exp(input int lo, input int hi, input logic [7:0] xm);
    for (int p = lo; p <= hi; p++)
      for (int i = 0; i < 188; i++) exp_q.push_back({i == 0, pb(i, xm)});
  endtask

  initial begin
    tbl[0] = '{"aligned",   0, 4, 0, 8'h00, 0, 3, 4, 1, 0, 1, 0};
    tbl[1] = '{"junk",      5, 4, 0, 8'h00, 0, 3, 4, 1, 0, 1, 0};
    tbl[2] = '{"sync_loss", 0, 8, 5, 8'h80, 0, 3, 4, 8, 8, 1, 1};
    tbl[3] = '{"toggle",    0, 6, 0, 8'h00, 1, 3, 6, 1, 0, 1, 0};

    @(posedge clk); #1;
    do_reset();
    chk("rst.valid", int'(ts_out_valid), 0);
    chk("rst.locked", int'(locked), 0);
    chk("rst.level", int'(fifo_level), 0);
    chk("rst.afull", int'(ts_usb_almost_full), 0);
    chk("rst.cnts", int'(sync_loss_cnt) + int'(overflow_cnt), 0);

    foreach (tbl[s]) begin
      int nbad;
      rmode = tbl[s].rm;
      do_reset();
      got_q.delete();
      exp_q.delete();
      add_exp(tbl[s].lo0, tbl[s].hi0, tbl[s].xm);
      add_exp(tbl[s].lo1, tbl[s].hi1, tbl[s].xm);
      for (int j = 0; j < tbl[s].junk; j++) put(8'(16 + j));
      for (int p = 1; p <= tbl[s].npkt; p++)
        for (int i = 0; i < 188; i++) begin
          if (p == tbl[s].bad_pkt + 1 && i == 0)
            chk($sformatf("%s.unlocked_before_pkt%0d", tbl[s].nm, p), int'(locked), 0);
          put((p == tbl[s].bad_pkt && i == 0) ? 8'h00 : pb(i, tbl[s].xm));
        end
      for (int c = 0; c < 4000; c++) begin
        @(posedge clk); #1;
        if (fifo_level == 0 && !ts_out_valid) break;
      end
      repeat (5) begin @(posedge clk); #1; end
      chk($sformatf("%s.count", tbl[s].nm), got_q.size(), exp_q.size());
      chk($sformatf("%s.first", tbl[s].nm), (got_q.size() > 0) ? int'(got_q[0]) : -1, 'h147);
      nbad = 0;
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
        if (got_q[k] !== exp_q[k]) nbad++;
      chk($sformatf("%s.data_mismatches", tbl[s].nm), nbad, 0);
      chk($sformatf("%s.locked", tbl[s].nm), int'(locked), tbl[s].exp_lock);
      chk($sformatf("%s.sync_loss", tbl[s].nm), int'(sync_loss_cnt), tbl[s].exp_sl);
      chk($sformatf("%s.overflow", tbl[s].nm), int'(overflow_cnt), 0);
    end

    // Lock with ready low so the output stalls on the sync byte, then fill the FIFO.
    rmode = 2;
    do_reset();
    for (int p = 1; p <= 2; p++)
      for (int i = 0; i < 188; i++) put(pb(i, 8'h80));
    put(8'h47);
    repeat (5) begin @(posedge clk); #1; end
    chk("ovf.locked", int'(locked), 1);
    chk("ovf.stall_word", int'({ts_out_valid, ts_out_start, ts_out_data}), 'h347);
    chk("ovf.level0", int'(fifo_level), 0);
    for (int k = 0; k < 1791; k++) put(8'h55);
    chk("ovf.level1791", int'(fifo_level), 1791);
    chk("ovf.afull_below", int'(ts_usb_almost_full), 0);
    put(8'h55);
    chk("ovf.level1792", int'(fifo_level), 1792);
    chk("ovf.afull_lag", int'(ts_usb_almost_full), 0);
    @(posedge clk); #1;
    chk("ovf.afull_set", int'(ts_usb_almost_full), 1);
    for (int k = 0; k < 256; k++) put(8'h55);
    chk("ovf.level_full", int'(fifo_level), 2048);
    chk("ovf.cnt_before", int'(overflow_cnt), 0);
    put(8'hAA);
    chk("ovf.cnt", int'(overflow_cnt), 1);
    chk("ovf.level_after", int'(fifo_level), 2048);
    chk("ovf.held_word", int'({ts_out_valid, ts_out_start, ts_out_data}), 'h347);

    do_reset();
    chk("ovf_rst.level", int'(fifo_level), 0);
    chk("ovf_rst.afull", int'(ts_usb_almost_full), 0);
    chk("ovf_rst.ovf", int'(overflow_cnt), 0);
    chk("ovf_rst.valid", int'(ts_out_valid), 0);
    chk("ovf_rst.locked", int'(locked), 0);

    // Reset in the middle of a forwarded packet, with a write on the reset cycle.
    rmode = 0;
    do_reset();
    for (int p = 1; p <= 3; p++)
      for (int i = 0; i < 188; i++) put(pb(i, 8'h00));
    for (int i = 0; i < 50; i++) put(pb(i, 8'h00));
    chk("mid_rst.locked_before", int'(locked), 1);
    chk("mid_rst.valid_before", int'(ts_out_valid), 1);
    reset = 1'b1;
    ts_usb_data = 8'h47;
    ts_usb_writereq = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ts_usb_writereq = 1'b0;
    chk("mid_rst.level", int'(fifo_level), 0);
    chk("mid_rst.valid", int'(ts_out_valid), 0);
    chk("mid_rst.locked", int'(locked), 0);
    chk("mid_rst.out_word", int'({ts_out_start, ts_out_data}), 0);

    chk("hold_violations", hold_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
